// File: rtl/mips32r2_tlb_search.sv
// MIPS32R2 main-TLB search block.
//
// Holds ENTRIES TLB slots plus a valid bit per slot and offers three ports:
//   write port  : w_valid / w_index / w_entry, writes a slot and marks it valid
//   read port   : r_index -> r_entry, registered one cycle later
//   fast side   : p_ivpn2 / p_iasid key from the fast-TLB miss path;
//                 p_ready / p_index / p_resp report the lowest matching slot
//   probe side  : sp_valid / sp_vpn2 / sp_asid start a software probe;
//                 sp_done pulses once with sp_hit / sp_index
//   sp_state    : probe FSM state (0 IDLE, 1 SCAN, 2 DONE) for observation
//
// Handshake: a probe request is accepted only in the cycle sp_valid=1 while the
// probe FSM is IDLE; sp_valid in any other state is ignored. Completion is the
// single-cycle sp_done pulse; sp_hit/sp_index stay stable from that pulse until
// the next request is accepted. The fast side has no request strobe: p_ready
// qualifies p_index/p_resp for the key currently on p_ivpn2/p_iasid.

package mips32r2_tlb_pkg;
  typedef enum logic [1:0] {PS4K = 2'd0, PS16K = 2'd1, PS64K = 2'd2, PS256K = 2'd3} page_size_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    page_size_t  ps;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic [4:0]  flags0;
    logic [4:0]  flags1;
  } tlb_entry_t;

  typedef enum logic [1:0] {SP_IDLE = 2'd0, SP_SCAN = 2'd1, SP_DONE = 2'd2} sp_state_t;
endpackage

module mips32r2_tlb_search
  import mips32r2_tlb_pkg::*;
#(
  parameter int ENTRIES    = 64,
  parameter int GROUP_SIZE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       w_valid,
  input  logic [$clog2(ENTRIES)-1:0] w_index,
  input  tlb_entry_t                 w_entry,
  input  logic [$clog2(ENTRIES)-1:0] r_index,
  output tlb_entry_t                 r_entry,
  input  logic [18:0]                p_ivpn2,
  input  logic [7:0]                 p_iasid,
  output logic                       p_ready,
  output logic [$clog2(ENTRIES)-1:0] p_index,
  output tlb_entry_t                 p_resp,
  input  logic                       sp_valid,
  input  logic [18:0]                sp_vpn2,
  input  logic [7:0]                 sp_asid,
  output logic                       sp_done,
  output logic                       sp_hit,
  output logic [$clog2(ENTRIES)-1:0] sp_index,
  output logic [1:0]                 sp_state
);

  localparam int IDXW    = $clog2(ENTRIES);
  localparam int NGROUPS = ENTRIES / GROUP_SIZE;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [GW-1:0] LAST_GROUP = GW'(NGROUPS - 1);

  function automatic logic [18:0] vpn_mask(input page_size_t ps);
    case (ps)
      PS16K:   return 19'h7FFFC;
      PS64K:   return 19'h7FFF0;
      default: return 19'h7FFFF;
    endcase
  endfunction

  function automatic logic entry_match(input tlb_entry_t e, input logic v,
                                       input logic [18:0] kvpn, input logic [7:0] kasid);
    return v && (((e.vpn2 ^ kvpn) & vpn_mask(e.ps)) == 19'd0) && (e.g || (e.asid == kasid));
  endfunction

  function automatic logic [IDXW-1:0] slot_of(input logic [GW-1:0] grp, input int i);
    return IDXW'(int'(grp) * GROUP_SIZE + i);
  endfunction

  function automatic logic [GW-1:0] next_group(input logic [GW-1:0] grp);
    return (grp == LAST_GROUP) ? '0 : grp + GW'(1);
  endfunction

  // ---------------- storage ----------------
  tlb_entry_t         slots [ENTRIES];
  logic [ENTRIES-1:0] slot_valid;

  // Slot data is deliberately not reset; only the valid bits are.
  always_ff @(posedge clock) begin
    if (w_valid) slots[w_index] <= w_entry;
  end

  always_ff @(posedge clock) begin
    if (reset)        slot_valid <= '0;
    else if (w_valid) slot_valid[w_index] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) r_entry <= '0;
    else       r_entry <= slots[r_index];
  end

  // ---------------- fast-side scanner ----------------
  logic [26:0]     p_key, prev_key, s1_key;
  logic [GW-1:0]   gptr, f_grp;
  logic            f_hit;
  logic [IDXW-1:0] f_idx;
  logic            s1_hit, s1_hold;
  logic [IDXW-1:0] s1_index;
  tlb_entry_t      s1_entry;

  assign p_key = {p_ivpn2, p_iasid};

  // A new key compares group 0 in the very cycle it appears, so the worst case
  // (hit in the last group) is reported NGROUPS cycles after the key change.
  always_comb begin
    f_grp = (p_key != prev_key) ? '0 : gptr;
    f_hit = 1'b0;
    f_idx = '0;
    // Descending walk so the lowest matching slot in the group wins.
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (entry_match(slots[slot_of(f_grp, i)], slot_valid[slot_of(f_grp, i)], p_ivpn2, p_iasid)) begin
        f_hit = 1'b1;
        f_idx = slot_of(f_grp, i);
      end
    end
  end

  // Once a hit for the current key is registered it is held; groups are
  // scanned in ascending order, so the held hit is the lowest matching slot.
  assign s1_hold = s1_hit && (s1_key == p_key);

  always_ff @(posedge clock) begin
    if (reset) begin
      gptr     <= '0;
      prev_key <= '0;
      s1_hit   <= 1'b0;
      s1_key   <= '0;
      s1_index <= '0;
      s1_entry <= '0;
    end else begin
      prev_key <= p_key;
      if (w_valid) begin
        // Table contents are changing: drop any hit and rescan from group 0.
        gptr   <= '0;
        s1_hit <= 1'b0;
      end else begin
        gptr <= next_group(f_grp);
        if (!s1_hold) begin
          s1_hit   <= f_hit;
          s1_index <= f_idx;
          s1_entry <= slots[f_idx];
          s1_key   <= p_key;
        end
      end
    end
  end

  assign p_ready = s1_hold && !w_valid;
  assign p_index = s1_index;
  assign p_resp  = s1_entry;

  // ---------------- software probe ----------------
  sp_state_t       state, state_next;
  logic [GW-1:0]   sgptr;
  logic [18:0]     sp_kvpn;
  logic [7:0]      sp_kasid;
  logic            s_hit;
  logic [IDXW-1:0] s_idx;

  // Dedicated comparators so the fast side never waits on a probe.
  always_comb begin
    s_hit = 1'b0;
    s_idx = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (entry_match(slots[slot_of(sgptr, i)], slot_valid[slot_of(sgptr, i)], sp_kvpn, sp_kasid)) begin
        s_hit = 1'b1;
        s_idx = slot_of(sgptr, i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= SP_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SP_IDLE: if (sp_valid) state_next = SP_SCAN;
      // A write during the scan restarts it, so it overrides a match.
      SP_SCAN: if (!w_valid && (s_hit || sgptr == LAST_GROUP)) state_next = SP_DONE;
      SP_DONE: state_next = SP_IDLE;
      default: state_next = SP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sgptr    <= '0;
      sp_kvpn  <= '0;
      sp_kasid <= '0;
      sp_hit   <= 1'b0;
      sp_index <= '0;
    end else begin
      case (state)
        SP_IDLE: if (sp_valid) begin
          sp_kvpn  <= sp_vpn2;
          sp_kasid <= sp_asid;
          sgptr    <= '0;
          sp_hit   <= 1'b0;
          sp_index <= '0;
        end
        SP_SCAN: begin
          if (w_valid) sgptr <= '0;
          else if (s_hit) begin
            sp_hit   <= 1'b1;
            sp_index <= s_idx;
          end else if (sgptr != LAST_GROUP) sgptr <= sgptr + GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sp_done  = (state == SP_DONE);
  assign sp_state = state;

endmodule

// File: doc/mips32r2_tlb_search.md
MIPS32R2_TLB_SEARCH -- requirements
Module: mips32r2_tlb_search

Interface
REQ-001 SHALL have parameters: ENTRIES, default 64, number of main TLB entries; GROUP_SIZE, default 4, entries compared per cycle (ENTRIES divisible by GROUP_SIZE).
REQ-002 SHALL have ports: clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: w_valid  in  1  TLB write strobe; w_index  in  $clog2(ENTRIES)  write slot; w_entry  in  TLBEntry  data to write.
REQ-004 SHALL have ports: r_index  in  $clog2(ENTRIES)  read slot; r_entry  out  TLBEntry  registered read data.
REQ-005 SHALL have ports: p_ivpn2  in  19  fast-TLB miss VPN2; p_iasid  in  8  fast-TLB ASID; p_ready  out  1  hit found; p_index  out  $clog2(ENTRIES)  hit slot; p_resp  out  TLBEntry  hit entry.
REQ-006 SHALL have ports: sp_valid  in  1  software probe request; sp_vpn2  in  19; sp_asid  in  8; sp_done  out  1  probe finished pulse; sp_hit  out  1; sp_index  out  $clog2(ENTRIES).

Function
REQ-007 SHALL hold ENTRIES TLBEntry slots plus one valid bit per slot; entries with valid=0 SHALL never match.
REQ-008 Match rule: valid && ((vpn2 ^ key_vpn2) & mask)==0 && (g || asid==key_asid); mask = 19'h7FFFC for PS16K, 19'h7FFF0 for PS64K, all ones otherwise.
REQ-009 w_valid SHALL write w_entry to slot w_index and set its valid bit at the clock edge; written data visible to all ports from the next cycle.
REQ-010 r_entry SHALL equal slot r_index as of the previous clock edge (1-cycle latency, write-first not required).
REQ-011 Fast-side scanner: group pointer gptr in 0..ENTRIES/GROUP_SIZE-1 compares slots gptr*GROUP_SIZE..+GROUP_SIZE-1 against p_ivpn2/p_iasid each cycle; gptr increments by 1, wraps to 0.
REQ-012 Within a group, lowest matching index SHALL be selected.
REQ-013 Compare result SHALL be registered (s1_hit, s1_index, s1_entry, s1_key); p_ready/p_index/p_resp driven from these registers.
REQ-014 p_ready SHALL be 1 only when s1_hit=1, s1_key equals current {p_ivpn2,p_iasid}, and w_valid=0.
REQ-015 When {p_ivpn2,p_iasid} differs from previous cycle's value, gptr SHALL restart at 0 that cycle (group 0 compared against the new key).
REQ-016 w_valid SHALL clear s1_hit and restart gptr at 0 next cycle.
REQ-017 Worst-case fast-side latency from stable key to p_ready: ENTRIES/GROUP_SIZE cycles (16 at defaults), within the consumer's miss window of ENTRIES/GROUP_SIZE+1 cycles.
REQ-018 p_index/p_resp SHALL be don't-care when p_ready=0.
REQ-019 Software probe FSM states: IDLE, SCAN, DONE.
REQ-020 IDLE: sp_valid=1 -> latch sp_vpn2/sp_asid, sgptr=0, go SCAN.
REQ-021 SCAN: compare group sgptr; first match -> record index, sp_hit=1, go DONE; else sgptr+1; after last group with no match -> sp_hit=0, go DONE.
REQ-022 DONE: sp_done=1 for exactly one cycle with sp_hit/sp_index valid, then IDLE; sp_hit/sp_index hold until next probe starts.
REQ-023 sp_valid ignored outside IDLE; probe latency 2..ENTRIES/GROUP_SIZE+1 cycles from acceptance to sp_done.
REQ-024 w_valid during SCAN SHALL restart the probe at sgptr=0 with the latched key.
REQ-025 Software probe SHALL use its own comparators; fast-side scanning never stalls.

Reset
REQ-026 On reset: all valid bits 0, gptr=0, sgptr=0, s1_hit=0, FSM=IDLE, p_ready=0, sp_done=0, sp_hit=0, sp_index=0, r_entry=0; slot data not cleared.
REQ-027 Reset mid-scan or mid-probe SHALL abort; no sp_done generated.

Verification
REQ-028 After reset, hold key vpn2=0x12345 asid=3 for 20 cycles -> p_ready=0 every cycle.
REQ-029 Write slot 61 {vpn2=0x12345, asid=3, g=0, PS4K}; present key next cycle -> p_ready=1, p_index=61 exactly 16 cycles after key change, held while key stable.
REQ-030 Slots 8 and 9 both match (slot 9 g=1, asid=7); key asid=5 -> p_index=8; rewrite slot 8 asid=6 -> p_index=9.
REQ-031 Slot 4 PS16K vpn2=0x00100; key vpn2=0x00103 -> hit index 4; key vpn2=0x00104 -> no hit.
REQ-032 sp_valid with key only in slot 0 -> sp_done 2 cycles later, sp_hit=1, sp_index=0; absent key -> sp_done after 17 cycles, sp_hit=0.
REQ-033 w_valid while p_ready=1 -> p_ready=0 that cycle; reset asserted in SCAN -> FSM IDLE, no sp_done.
